// File: rtl/param_rate_divider_pkg.sv
// Shared constants for the multi-channel rate divider: mode encoding and
// default sizing.
package param_rate_divider_pkg;

   localparam logic MODE_PERIODIC = 1'b0;
   localparam logic MODE_ONESHOT  = 1'b1;

   localparam int unsigned DEFAULT_WIDTH  = 32;
   localparam int unsigned DEFAULT_NUM_CH = 4;

endpackage

// File: rtl/rate_div_channel.sv
// One divider channel: period/mode/count/done registers and the
// terminal-count pulse.
module rate_div_channel
   import param_rate_divider_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             wr,
   input  logic [WIDTH-1:0] wr_period,
   input  logic             wr_oneshot,
   input  logic             enable,
   output logic             pulse,
   output logic             done,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] period;
   logic             oneshot;
   logic             active;
   logic             terminal;

   assign active   = enable && (period != '0) && !done;
   assign terminal = (count == '0);
   assign pulse    = active && terminal;

   // A write takes priority over the terminal-count reload, but the pulse
   // for that cycle is still driven from the pre-write state.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         period  <= '0;
         oneshot <= MODE_PERIODIC;
         count   <= '0;
         done    <= 1'b0;
      end else if (wr) begin
         period  <= wr_period;
         oneshot <= wr_oneshot;
         count   <= (wr_period == '0) ? '0 : wr_period - WIDTH'(1);
         done    <= 1'b0;
      end else if (active) begin
         if (!terminal)
            count <= count - WIDTH'(1);
         else if (oneshot == MODE_ONESHOT)
            done <= 1'b1;
         else
            count <= period - WIDTH'(1);
      end
   end

endmodule

// File: rtl/param_rate_divider.sv
// Multi-channel programmable rate divider: write decode, per-channel
// instances and the live-counter readback mux.
module param_rate_divider
   import param_rate_divider_pkg::*;
#(
   parameter int unsigned WIDTH  = DEFAULT_WIDTH,
   parameter int unsigned NUM_CH = DEFAULT_NUM_CH,
   localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              wr_en,
   input  logic [CH_W-1:0]   wr_ch,
   input  logic [WIDTH-1:0]  wr_period,
   input  logic              wr_oneshot,
   input  logic [NUM_CH-1:0] enable,
   output logic [NUM_CH-1:0] pulse,
   output logic [NUM_CH-1:0] done,
   input  logic [CH_W-1:0]   rd_ch,
   output logic [WIDTH-1:0]  rd_count
);

   logic [NUM_CH-1:0] wr_sel;
   logic [WIDTH-1:0]  counts [NUM_CH];

   // Out-of-range channel indices match no instance, so such writes drop.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign wr_sel[i] = wr_en && (wr_ch == CH_W'(i));

      rate_div_channel #(
         .WIDTH (WIDTH)
      ) u_channel (
         .clock      (clock),
         .resetn     (resetn),
         .wr         (wr_sel[i]),
         .wr_period  (wr_period),
         .wr_oneshot (wr_oneshot),
         .enable     (enable[i]),
         .pulse      (pulse[i]),
         .done       (done[i]),
         .count      (counts[i])
      );
   end

   always_comb begin
      rd_count = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (rd_ch == CH_W'(i))
            rd_count = counts[i];
      end
   end

endmodule

// File: tb/tb_param_rate_divider.sv
// Self-checking bench for param_rate_divider: directed vector table, corner
// sequences and random traffic against an elapsed-cycle reference model.
module tb_param_rate_divider;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       wr_en = 1'b0;
   logic [1:0] wr_ch = '0;
   logic [7:0] wr_period = '0;
   logic       wr_oneshot = 1'b0;
   logic [3:0] enable = '0;
   logic [3:0] pulse;
   logic [3:0] done;
   logic [1:0] rd_ch = '0;
   logic [7:0] rd_count;

   // Three-channel instance: exercises writes to a non-existent channel.
   logic       wr_en3 = 1'b0;
   logic [1:0] wr_ch3 = '0;
   logic [2:0] enable3 = '0;
   logic [2:0] pulse3;
   logic [2:0] done3;
   logic [1:0] rd_ch3 = '0;
   logic [7:0] rd_count3;

   param_rate_divider #(.WIDTH(8), .NUM_CH(4)) dut (
      .clock(clock), .resetn(resetn), .wr_en(wr_en), .wr_ch(wr_ch),
      .wr_period(wr_period), .wr_oneshot(wr_oneshot), .enable(enable),
      .pulse(pulse), .done(done), .rd_ch(rd_ch), .rd_count(rd_count)
   );

   param_rate_divider #(.WIDTH(8), .NUM_CH(3)) dut3 (
      .clock(clock), .resetn(resetn), .wr_en(wr_en3), .wr_ch(wr_ch3),
      .wr_period(wr_period), .wr_oneshot(wr_oneshot), .enable(enable3),
      .pulse(pulse3), .done(done3), .rd_ch(rd_ch3), .rd_count(rd_count3)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: per channel, the period, the mode and the number of
   // enabled cycles elapsed since the last write.
   int unsigned m_p  [4];
   bit          m_os [4];
   int unsigned m_n  [4];

   function automatic bit m_done(int i);
      return m_os[i] && (m_p[i] != 0) && (m_n[i] >= m_p[i]);
   endfunction

   function automatic int unsigned m_count(int i);
      if (m_p[i] == 0 || m_done(i)) return 0;
      return m_p[i] - 1 - (m_n[i] % m_p[i]);
   endfunction

   function automatic bit m_pulse(int i, logic [3:0] en);
      return en[i] && (m_p[i] != 0) && !m_done(i) && ((m_n[i] % m_p[i]) == m_p[i] - 1);
   endfunction

   function automatic void m_reset();
      for (int i = 0; i < 4; i++) begin
         m_p[i] = 0; m_os[i] = 0; m_n[i] = 0;
      end
   endfunction

   function automatic void m_edge(logic we, logic [1:0] wc, logic [7:0] wp, logic wo, logic [3:0] en);
      for (int i = 0; i < 4; i++) begin
         if (we && int'(wc) == i) begin
            m_p[i] = int'(wp); m_os[i] = wo; m_n[i] = 0;
         end else if (en[i] && m_p[i] != 0 && !m_done(i)) begin
            if (m_os[i]) m_n[i] = m_n[i] + 1;
            else         m_n[i] = (m_n[i] + 1) % m_p[i];
         end
      end
   endfunction

   logic [3:0] obs_pulse;
   logic [3:0] obs_done;
   logic [7:0] obs_rd;

   task automatic step(input logic we, input logic [1:0] wc, input logic [7:0] wp,
                       input logic wo, input logic [3:0] en, input logic [1:0] rc);
      logic [3:0] ep;
      logic [3:0] ed;
      @(negedge clock);
      wr_en = we; wr_ch = wc; wr_period = wp; wr_oneshot = wo; enable = en; rd_ch = rc;
      #1;
      for (int i = 0; i < 4; i++) begin
         ep[i] = m_pulse(i, en);
         ed[i] = m_done(i);
      end
      obs_pulse = pulse; obs_done = done; obs_rd = rd_count;
      chk("pulse", 32'(pulse), 32'(ep));
      chk("done", 32'(done), 32'(ed));
      chk("rd_count", 32'(rd_count), m_count(int'(rc)));
      m_edge(we, wc, wp, wo, en);
   endtask

   task automatic do_reset(input logic [3:0] en);
      @(negedge clock);
      wr_en = 1'b0; wr_en3 = 1'b0; enable = en; rd_ch = '0; resetn = 1'b0;
      #1;
      chk("rst_pulse", 32'(pulse), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_rd_count", 32'(rd_count), 0);
      m_reset();
      @(negedge clock);
      resetn = 1'b1;
   endtask

   typedef struct packed {
      logic       we;
      logic [1:0] wc;
      logic [7:0] wp;
      logic       wo;
      logic [3:0] en;
      logic [1:0] rc;
      logic [3:0] ep;
      logic [3:0] ed;
      logic [7:0] er;
   } vec_t;

   vec_t tbl [20];

   initial begin
      int got;
      int first;
      int second;
      logic [3:0] en;
      logic [7:0] p;

      // Periodic P=4 on ch0, then halt ch0 and run a one-shot P=3 on ch1.
      tbl[0]  = '{1'b1, 2'd0, 8'd4, 1'b0, 4'b0001, 2'd0, 4'b0000, 4'b0000, 8'd0};
      tbl[1]  = '{1'b0, 2'd0, 8'd0, 1'b0, 4'b0001, 2'd0, 4'b0000, 4'b0000, 8'd3};
      tbl[2]  = '{1'b0, 2'd0, 8'd0, 1'b0, 4'b0001, 2'd0, 4'b0000, 4'b0000, 8'd2};
      tbl[3]  = '{1'b0, 2'd0, 8'd0, 1'b0, 4'b0001, 2'd0, 4'b0000, 4'b0000, 8'd1};
      tbl[4]  = '{1'b0, 2'd0, 8'd0, 1'b0, 4'b0001, 2'd0, 4'b0001, 4'b0000, 8'd0};
      tbl[5]  = '{1'b0, 2'd0, 8'd0, 1'b0, 4'b0001, 2'd0, 4'b0000, 4'b0000, 8'd3};
      tbl[6]  = '{1'b0, 2'd0, 8'd0, 1'b0, 4'b0001, 2'd0, 4'b0000, 4'b0000, 8'd2};
      tbl[7]  = '{1'b0, 2'd0, 8'd0, 1'b0, 4'b0001, 2'd0, 4'b0000, 4'b0000, 8'd1};
      tbl[8]  = '{1'b0, 2'd0, 8'd0, 1'b0, 4'b0001, 2'd0, 4'b0001, 4'b0000, 8'd0};
      tbl[9]  = '{1'b0, 2'd0, 8'd0, 1'b0, 4'b0001, 2'd0, 4'b0000, 4'b0000, 8'd3};
      tbl[10] = '{1'b0, 2'd0, 8'd0, 1'b0, 4'b0001, 2'd0, 4'b0000, 4'b0000, 8'd2};
      tbl[11] = '{1'b0, 2'd0, 8'd0, 1'b0, 4'b0001, 2'd0, 4'b0000, 4'b0000, 8'd1};
      tbl[12] = '{1'b0, 2'd0, 8'd0, 1'b0, 4'b0001, 2'd0, 4'b0001, 4'b0000, 8'd0};
      tbl[13] = '{1'b1, 2'd0, 8'd0, 1'b0, 4'b0001, 2'd0, 4'b0000, 4'b0000, 8'd3};
      tbl[14] = '{1'b1, 2'd1, 8'd3, 1'b1, 4'b0011, 2'd1, 4'b0000, 4'b0000, 8'd0};
      tbl[15] = '{1'b0, 2'd0, 8'd0, 1'b0, 4'b0011, 2'd1, 4'b0000, 4'b0000, 8'd2};
      tbl[16] = '{1'b0, 2'd0, 8'd0, 1'b0, 4'b0011, 2'd1, 4'b0000, 4'b0000, 8'd1};
      tbl[17] = '{1'b0, 2'd0, 8'd0, 1'b0, 4'b0011, 2'd1, 4'b0010, 4'b0000, 8'd0};
      tbl[18] = '{1'b0, 2'd0, 8'd0, 1'b0, 4'b0011, 2'd1, 4'b0000, 4'b0010, 8'd0};
      tbl[19] = '{1'b0, 2'd0, 8'd0, 1'b0, 4'b0011, 2'd1, 4'b0000, 4'b0010, 8'd0};

      do_reset(4'b1111);

      for (int k = 0; k < 20; k++) begin
         step(tbl[k].we, tbl[k].wc, tbl[k].wp, tbl[k].wo, tbl[k].en, tbl[k].rc);
         chk($sformatf("tbl%0d_pulse", k), 32'(obs_pulse), 32'(tbl[k].ep));
         chk($sformatf("tbl%0d_done", k), 32'(obs_done), 32'(tbl[k].ed));
         chk($sformatf("tbl%0d_rd", k), 32'(obs_rd), 32'(tbl[k].er));
      end

      // One-shot stays silent once done.
      for (int k = 0; k < 20; k++) begin
         step(1'b0, 2'd0, 8'd0, 1'b0, 4'b0011, 2'd1);
         chk("oneshot_quiet", 32'(obs_pulse[1]), 0);
         chk("oneshot_done", 32'(obs_done[1]), 1);
      end

      // Pause at count 2, hold for 7 cycles, resume.
      do_reset(4'b0000);
      step(1'b1, 2'd0, 8'd5, 1'b0, 4'b0001, 2'd0);
      for (int k = 0; k < 10 && m_count(0) != 2; k++)
         step(1'b0, 2'd0, 8'd0, 1'b0, 4'b0001, 2'd0);
      for (int k = 0; k < 7; k++) begin
         step(1'b0, 2'd0, 8'd0, 1'b0, 4'b0000, 2'd0);
         chk("pause_hold", 32'(obs_rd), 2);
         chk("pause_nopulse", 32'(obs_pulse[0]), 0);
      end
      got = 999;
      for (int k = 0; k < 10; k++) begin
         step(1'b0, 2'd0, 8'd0, 1'b0, 4'b0001, 2'd0);
         if (obs_pulse[0]) begin got = k; break; end
      end
      chk("pause_resume", got, 2);

      // P=1 pulses every enabled cycle; P=0 never pulses.
      step(1'b1, 2'd2, 8'd1, 1'b0, 4'b0000, 2'd2);
      step(1'b1, 2'd3, 8'd0, 1'b0, 4'b0000, 2'd3);
      for (int k = 0; k < 8; k++) begin
         step(1'b0, 2'd0, 8'd0, 1'b0, 4'b1100, 2'd2);
         chk("p1_pulse", 32'(obs_pulse[2]), 1);
         chk("p0_nopulse", 32'(obs_pulse[3]), 0);
      end

      // Full-scale period.
      step(1'b1, 2'd0, 8'd255, 1'b0, 4'b0000, 2'd0);
      first = 0; second = 0;
      for (int k = 1; k <= 600 && second == 0; k++) begin
         step(1'b0, 2'd0, 8'd0, 1'b0, 4'b0001, 2'd0);
         if (obs_pulse[0]) begin
            if (first == 0) first = k;
            else second = k;
         end
      end
      chk("p255_first", first, 255);
      chk("p255_interval", second - first, 255);

      // Write landing on a terminal-count cycle; ch3 runs alongside.
      do_reset(4'b0000);
      step(1'b1, 2'd2, 8'd3, 1'b0, 4'b1100, 2'd2);
      step(1'b1, 2'd3, 8'd2, 1'b0, 4'b1100, 2'd3);
      for (int k = 0; k < 10 && !m_pulse(2, 4'b1100); k++)
         step(1'b0, 2'd0, 8'd0, 1'b0, 4'b1100, 2'd2);
      step(1'b1, 2'd2, 8'd6, 1'b0, 4'b1100, 2'd2);
      chk("collide_pulse", 32'(obs_pulse[2]), 1);
      got = 999;
      for (int k = 1; k <= 20; k++) begin
         step(1'b0, 2'd0, 8'd0, 1'b0, 4'b1100, 2'd3);
         if (obs_pulse[2]) begin got = k; break; end
      end
      chk("collide_next", got, 6);

      // Reset mid-count with pulses and done active.
      step(1'b1, 2'd1, 8'd2, 1'b1, 4'b1111, 2'd0);
      step(1'b1, 2'd0, 8'd7, 1'b0, 4'b1111, 2'd0);
      step(1'b1, 2'd2, 8'd1, 1'b0, 4'b1111, 2'd0);
      for (int k = 0; k < 4; k++)
         step(1'b0, 2'd0, 8'd0, 1'b0, 4'b1111, 2'd0);
      do_reset(4'b1111);
      for (int k = 0; k < 5; k++) begin
         step(1'b0, 2'd0, 8'd0, 1'b0, 4'b1111, 2'd0);
         chk("post_reset_halt", 32'(obs_pulse), 0);
      end

      // Random traffic against the model.
      for (int k = 0; k < 400; k++) begin
         case ($urandom_range(0, 9))
            0:       p = 8'd0;
            1:       p = 8'd255;
            2:       p = 8'd254;
            default: p = 8'($urandom_range(1, 8));
         endcase
         for (int i = 0; i < 4; i++) en[i] = ($urandom_range(0, 3) != 0);
         step(($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)), p,
              1'($urandom_range(0, 1)), en, 2'($urandom_range(0, 3)));
      end

      // Writes to a non-existent channel are dropped.
      do_reset(4'b0000);
      @(negedge clock);
      enable = '0; wr_period = 8'd2; wr_oneshot = 1'b0;
      wr_en3 = 1'b1; wr_ch3 = 2'd0; enable3 = 3'b001; rd_ch3 = 2'd0;
      @(negedge clock);
      wr_en3 = 1'b1; wr_ch3 = 2'd3; wr_period = 8'd1; rd_ch3 = 2'd3;
      #1;
      chk("nch3_rd_invalid", 32'(rd_count3), 0);
      @(negedge clock);
      wr_en3 = 1'b0; rd_ch3 = 2'd0;
      #1;
      chk("nch3_pulse_b", 32'(pulse3), 32'(3'b001));
      chk("nch3_rd_b", 32'(rd_count3), 0);
      @(negedge clock);
      #1;
      chk("nch3_pulse_c", 32'(pulse3), 0);
      chk("nch3_rd_c", 32'(rd_count3), 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/param_rate_divider.md
PARAM_RATE_DIVIDER -- requirements
Module: param_rate_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32: bit width of each channel's period and counter.
REQ-002 SHALL have parameter NUM_CH, default 4: number of independent divider channels (1..16).
REQ-003 SHALL derive localparam CH_W = max(1, clog2(NUM_CH)): width of the channel-select field.
REQ-004 SHALL have port clock, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port wr_en, input, 1: one-cycle strobe that writes a channel's configuration.
REQ-007 SHALL have port wr_ch, input, CH_W: channel index for the write; values >= NUM_CH are ignored.
REQ-008 SHALL have port wr_period, input, WIDTH: period P in clock cycles.
REQ-009 SHALL have port wr_oneshot, input, 1: mode (0 = periodic, 1 = one-shot).
REQ-010 SHALL have port enable, input, NUM_CH: per-channel count enable.
REQ-011 SHALL have port pulse, output, NUM_CH: per-channel terminal-count pulse.
REQ-012 SHALL have port done, output, NUM_CH: per-channel one-shot-complete flag.
REQ-013 SHALL have port rd_ch, input, CH_W: readback channel select.
REQ-014 SHALL have port rd_count, output, WIDTH: live counter of channel rd_ch (combinational mux); reads 0 if rd_ch >= NUM_CH.

Function
REQ-015 Each channel SHALL hold the registers period, oneshot, count (WIDTH bits) and done.
REQ-016 A write (wr_en=1, valid wr_ch) SHALL, at the clock edge:
  - load period and oneshot;
  - set count = P-1, or 0 if P=0;
  - clear done.
REQ-017 pulse[i] SHALL be combinational from registered state: enable[i] & (count==0) & (period!=0) & !done[i].
REQ-018 With enable[i]=1, P!=0 and done=0, each edge SHALL decrement count; at count==0 it SHALL instead reload P-1, wrapping with no dead cycle.
REQ-019 As a result of REQ-018, a periodic channel SHALL pulse exactly once every P enabled cycles; P=1 SHALL pulse every enabled cycle.
REQ-020 With enable[i]=0, count and done SHALL hold and pulse[i] SHALL be 0. Re-enabling SHALL resume from the held count.
REQ-021 P=0 SHALL mean channel halted: count stays 0, pulse stays 0, done unchanged.
REQ-022 In one-shot mode, the edge ending a pulse cycle SHALL set done=1 and leave count at 0. The channel then halts until it is rewritten.
REQ-023 A write and a terminal count on the same channel in the same cycle: pulse SHALL still be asserted that cycle, and the write SHALL win at the edge (count = new P-1, done = 0).
REQ-024 A write to channel j SHALL NOT affect any channel other than j.
REQ-025 All counter arithmetic SHALL be unsigned WIDTH-bit; P = 2^WIDTH-1 SHALL work without overflow.

Reset
REQ-026 resetn=0 SHALL asynchronously clear, for every channel: period=0, oneshot=0, count=0, done=0.
REQ-027 Outputs during and after reset SHALL be: pulse=0, done=0, rd_count=0.
REQ-028 Reset asserted mid-count SHALL abort immediately. After release, a channel stays halted until it is rewritten.

Structure
REQ-029 A shared package SHALL hold:
  - the mode encoding constants MODE_PERIODIC=0 and MODE_ONESHOT=1;
  - the default WIDTH and NUM_CH values.
REQ-030 One channel's state and logic SHALL be the sub-module rate_div_channel, instantiated NUM_CH times by a generate loop.
REQ-031 The top level SHALL contain only write decode, instantiation and the readback mux.

Verification
REQ-032 Periodic: write ch0 P=4 periodic, enable[0]=1 held -> pulse[0] high on cycles 4, 8 and 12 after the write edge; rd_count sequence 3,2,1,0,3.
REQ-033 One-shot: write ch1 P=3 one-shot, enable=1 -> a single pulse 3 cycles after the write; done[1]=1 from the next edge; no further pulses over 20 cycles.
REQ-034 Pause: ch0 P=5, drop enable for 7 cycles at count=2 -> count held at 2, no pulse; after re-enable, pulse arrives 2 cycles later.
REQ-035 Boundaries:
  - P=1 -> pulse every enabled cycle;
  - P=0 -> no pulses;
  - WIDTH=8, P=255 -> pulse every 255 cycles.
REQ-036 Collision/reset:
  - write ch2 P=6 in ch2's terminal-count cycle -> pulse seen that cycle, next pulse 6 cycles later, ch3 unaffected;
  - resetn low mid-count -> all outputs 0 within the same cycle.
